// File: rtl/pwm_sequencer_pkg.sv
// Shared definitions for the PWM sequencer and the carrier generator:
// FSM state encodings and the default carrier timing.
package pwm_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    localparam int NB_DATA_DEF      = 16;
    localparam int DIV_RATIO_DEF    = 24;  // 5.4 MHz / 225 kHz
    localparam int PERIOD_TICKS_DEF = 31;
    localparam int DEAD_CYCLES_DEF  = 8;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_sequencer_dead_time.sv
// dead_time_gen: turns a raw PWM level into a complementary gate pair with
// a fixed both-off gap after every raw transition.
module dead_time_gen
    import pwm_sequencer_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_enable,
    input  logic i_raw,
    output logic o_gate_hi,
    output logic o_gate_lo
);

    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES - 1);

    logic       raw_prev_q, raw_prev_d;
    logic [3:0] cnt_q, cnt_d;
    logic       gate_hi_q, gate_hi_d;
    logic       gate_lo_q, gate_lo_d;

    // While disabled the counter is kept preloaded, so the first gate after
    // enable is also preceded by a full dead interval.
    always_comb begin
        raw_prev_d = i_raw;
        cnt_d      = cnt_q;
        gate_hi_d  = 1'b0;
        gate_lo_d  = 1'b0;
        if (!i_enable) begin
            cnt_d = DEAD_LOAD;
        end else if (i_raw != raw_prev_q) begin
            cnt_d = DEAD_LOAD;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            gate_hi_d = i_raw;
            gate_lo_d = ~i_raw;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            raw_prev_q <= 1'b0;
            cnt_q      <= 4'd0;
            gate_hi_q  <= 1'b0;
            gate_lo_q  <= 1'b0;
        end else begin
            raw_prev_q <= raw_prev_d;
            cnt_q      <= cnt_d;
            gate_hi_q  <= gate_hi_d;
            gate_lo_q  <= gate_lo_d;
        end
    end

    assign o_gate_hi = gate_hi_q;
    assign o_gate_lo = gate_lo_q;

endmodule

// File: rtl/pwm_sequencer.sv
// PWM sequencer: run/fault FSM, carrier tick divider, period-aligned
// reference update, compare against the carrier and dead-time gate drive.
module pwm_sequencer
    import pwm_sequencer_pkg::*;
#(
    parameter int NB_DATA      = NB_DATA_DEF,
    parameter int DIV_RATIO    = DIV_RATIO_DEF,
    parameter int PERIOD_TICKS = PERIOD_TICKS_DEF,
    parameter int DEAD_CYCLES  = DEAD_CYCLES_DEF
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_run,
    input  logic                      i_fault,
    input  logic signed [NB_DATA-1:0] i_carrier,
    input  logic signed [NB_DATA-1:0] i_ref,
    input  logic                      i_ref_valid,
    output logic                      o_carrier_en,
    output logic                      o_carrier_rst,
    output logic                      o_gate_hi,
    output logic                      o_gate_lo,
    output logic                      o_period_start,
    output logic [1:0]                o_state,
    output logic                      o_fault_latched
);

    localparam int                DIV_W     = cnt_width(DIV_RATIO);
    localparam int                TICK_W    = cnt_width(PERIOD_TICKS);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_RATIO - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD_TICKS - 1);

    state_e                    state_q, state_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [TICK_W-1:0]         tick_q, tick_d;
    logic                      carrier_en_q, carrier_en_d;
    logic                      period_start_q, period_start_d;
    logic                      stop_q, stop_d;
    logic                      carrier_rst_q, carrier_rst_d;
    logic                      fault_latched_q, fault_latched_d;
    logic                      raw_pwm_q, raw_pwm_d;
    logic signed [NB_DATA-1:0] shadow_q, shadow_d;
    logic signed [NB_DATA-1:0] active_q, active_d;
    logic                      strobe, wrap, gate_en;

    always_comb begin
        strobe          = (div_q == DIV_LAST);
        wrap            = strobe && (tick_q == TICK_LAST);
        state_d         = state_q;
        div_d           = div_q;
        tick_d          = tick_q;
        carrier_en_d    = 1'b0;
        period_start_d  = 1'b0;
        stop_d          = stop_q;
        shadow_d        = i_ref_valid ? i_ref : shadow_q;
        active_d        = period_start_q ? shadow_q : active_q;
        raw_pwm_d       = (active_q > i_carrier);

        case (state_q)
            ST_IDLE: begin
                if (i_run) state_d = ST_ARM;
            end
            ST_ARM, ST_RUN: begin
                div_d = strobe ? '0 : div_q + DIV_W'(1);
                if (strobe) tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
                carrier_en_d   = strobe;
                period_start_d = wrap;
                // A stop request is remembered so the period always completes.
                if (!i_run) stop_d = 1'b1;
                if (wrap) state_d = (stop_q || !i_run) ? ST_IDLE : ST_RUN;
            end
            ST_FAULT: begin
                if (!i_run) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_fault) state_d = ST_FAULT;

        // Leaving the active states clears the timing chain for the next ARM.
        if (state_d != ST_ARM && state_d != ST_RUN) begin
            div_d          = '0;
            tick_d         = '0;
            carrier_en_d   = 1'b0;
            period_start_d = 1'b0;
            stop_d         = 1'b0;
        end

        carrier_rst_d   = (state_d == ST_IDLE) || (state_d == ST_FAULT);
        fault_latched_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q         <= ST_IDLE;
            div_q           <= '0;
            tick_q          <= '0;
            carrier_en_q    <= 1'b0;
            period_start_q  <= 1'b0;
            stop_q          <= 1'b0;
            carrier_rst_q   <= 1'b1;
            fault_latched_q <= 1'b0;
            raw_pwm_q       <= 1'b0;
            shadow_q        <= '0;
            active_q        <= '0;
        end else begin
            state_q         <= state_d;
            div_q           <= div_d;
            tick_q          <= tick_d;
            carrier_en_q    <= carrier_en_d;
            period_start_q  <= period_start_d;
            stop_q          <= stop_d;
            carrier_rst_q   <= carrier_rst_d;
            fault_latched_q <= fault_latched_d;
            raw_pwm_q       <= raw_pwm_d;
            shadow_q        <= shadow_d;
            active_q        <= active_d;
        end
    end

    // Enable follows the next state so gates drop in the same clock the
    // FSM leaves RUN.
    assign gate_en = (state_d == ST_RUN);

    dead_time_gen #(
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_dead_time (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .i_enable (gate_en),
        .i_raw    (raw_pwm_q),
        .o_gate_hi(o_gate_hi),
        .o_gate_lo(o_gate_lo)
    );

    assign o_carrier_en    = carrier_en_q;
    assign o_carrier_rst   = carrier_rst_q;
    assign o_period_start  = period_start_q;
    assign o_state         = state_q;
    assign o_fault_latched = fault_latched_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer: carrier timing, duty, dead-time,
// reference update, fault handling, stop and reset behaviour.
module tb_pwm_sequencer;

    localparam int PT   = 31;
    localparam int DEAD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, run, fault, ref_valid;
    logic signed [15:0] carrier, ref_in;
    logic               en, crst, hi, lo, ps, flt;
    logic [1:0]         st;

    int n_asrt = 0;
    int n_fail = 0;
    int bt, en_cnt, last_gate, lowrun;
    bit manual, dt_chk;
    int first, second, cyc, nhi, nlo, bad;
    bit found;

    pwm_sequencer dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_run          (run),
        .i_fault        (fault),
        .i_carrier      (carrier),
        .i_ref          (ref_in),
        .i_ref_valid    (ref_valid),
        .o_carrier_en   (en),
        .o_carrier_rst  (crst),
        .o_gate_hi      (hi),
        .o_gate_lo      (lo),
        .o_period_start (ps),
        .o_state        (st),
        .o_fault_latched(flt)
    );

    // Symmetric triangle over 31 ticks: -32768 up to 30652 at tick 15 and back.
    function automatic logic signed [15:0] tri_wave(input int t);
        int v;
        if (t <= 15) v = -32768 + 4228 * t;
        else         v = 30652 - 4228 * (t - 15);
        return 16'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("gates_exclusive", 32'(hi & lo), 0);
        if (en) en_cnt++;
        if (st == 2'd0 || st == 2'd3) bt = 0;
        else if (en) bt = (bt == PT - 1) ? 0 : bt + 1;
        if (!manual) carrier = tri_wave(bt);
        if (st != 2'd2) begin
            last_gate = 0;
            lowrun    = 0;
        end else if (hi || lo) begin
            if (dt_chk && last_gate != 0 && lowrun > 0) chk("dead_gap", 32'(lowrun), DEAD);
            last_gate = hi ? 1 : 2;
            lowrun    = 0;
        end else begin
            lowrun++;
        end
    endtask

    task automatic wait_ps(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (!ok && cycles < 800) begin
            step();
            cycles++;
            if (ps) ok = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; fault = 1'b0; ref_valid = 1'b0;
        ref_in = '0; carrier = '0; manual = 1'b0; dt_chk = 1'b1;
        bt = 0; en_cnt = 0; last_gate = 0; lowrun = 0;

        // Reset state
        repeat (3) step();
        chk("rst_state", 32'(st), 0);
        chk("rst_carrier_rst", 32'(crst), 1);
        chk("rst_carrier_en", 32'(en), 0);
        chk("rst_gate_hi", 32'(hi), 0);
        chk("rst_gate_lo", 32'(lo), 0);
        chk("rst_period_start", 32'(ps), 0);
        chk("rst_fault_latched", 32'(flt), 0);

        // ARM timing: strobes every 24 clocks, RUN after 31 strobes
        rst_n = 1'b1; run = 1'b1; ref_in = 16'sh4000; ref_valid = 1'b1;
        step();
        ref_valid = 1'b0;
        en_cnt = 0;
        chk("arm_state", 32'(st), 1);
        chk("arm_carrier_rst", 32'(crst), 0);
        first = 0; second = 0; bad = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (hi || lo) bad++;
            if (en && first == 0) first = k;
            else if (en && second == 0) second = k;
        end
        chk("first_en_clock", 32'(first), 24);
        chk("second_en_clock", 32'(second), 48);
        cyc = 60; found = 1'b0;
        while (!found && cyc < 800) begin
            step();
            cyc++;
            if (st == 2'd1 && (hi || lo)) bad++;
            if (ps) found = 1'b1;
        end
        chk("run_entry_found", 32'(found), 1);
        chk("run_entry_clock", 32'(cyc), 744);
        chk("run_entry_state", 32'(st), 2);
        chk("arm_strobe_count", 32'(en_cnt), 31);
        chk("arm_gates_low", 32'(bad), 0);

        // Duty with 0x4000 against the triangle, measured on a settled period
        wait_ps(cyc, found);
        chk("period_clocks", 32'(cyc), 744);
        cyc = 0; nhi = 0; nlo = 0; found = 1'b0;
        while (!found && cyc < 800) begin
            step();
            cyc++;
            if (hi) nhi++;
            if (lo) nlo++;
            if (ps) found = 1'b1;
        end
        chk("period2_clocks", 32'(cyc), 744);
        chk("duty_hi_clocks", 32'(nhi), 568);
        chk("duty_lo_clocks", 32'(nlo), 160);

        // Raw toggled twice inside the dead interval
        manual = 1'b1; carrier = '0;
        repeat (12) step();
        chk("pre_toggle_hi", 32'(hi), 1);
        dt_chk = 1'b0;
        carrier = 16'sh7000;
        step();
        chk("toggle_hi_still", 32'(hi), 1);
        step();
        chk("toggle_gap_hi", 32'(hi), 0);
        chk("toggle_gap_lo", 32'(lo), 0);
        carrier = '0;
        bad = 0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) step();
            else step();
            if (hi || lo) bad++;
        end
        chk("retoggle_both_low", 32'(bad), 0);
        step();
        chk("retoggle_hi_after_dead", 32'(hi), 1);
        dt_chk = 1'b1;

        // Reference written mid-period takes effect only after period start
        carrier = 16'sh3000;
        wait_ps(cyc, found);
        chk("ref_sync_found", 32'(found), 1);
        repeat (300) step();
        ref_in = 16'sh2000; ref_valid = 1'b1;
        step();
        ref_valid = 1'b0;
        bad = 0; cyc = 0; found = 1'b0;
        while (!found && cyc < 800) begin
            step();
            cyc++;
            if (!hi) bad++;
            if (ps) found = 1'b1;
        end
        chk("ref_hold_found", 32'(found), 1);
        chk("ref_hold_hi", 32'(bad), 0);
        step();
        chk("ref_p1_hi", 32'(hi), 1);
        step();
        chk("ref_p2_hi", 32'(hi), 1);
        step();
        chk("ref_p3_hi", 32'(hi), 0);
        chk("ref_p3_lo", 32'(lo), 0);
        repeat (7) step();
        chk("ref_p10_lo", 32'(lo), 0);
        step();
        chk("ref_p11_lo", 32'(lo), 1);

        // Fault pulse while gate_hi is on
        carrier = 16'sh8000;
        repeat (12) step();
        chk("pre_fault_hi", 32'(hi), 1);
        fault = 1'b1;
        step();
        fault = 1'b0;
        chk("fault_gate_hi", 32'(hi), 0);
        chk("fault_gate_lo", 32'(lo), 0);
        chk("fault_state", 32'(st), 3);
        chk("fault_latched", 32'(flt), 1);
        chk("fault_carrier_rst", 32'(crst), 1);
        chk("fault_carrier_en", 32'(en), 0);
        repeat (3) step();
        chk("fault_hold_run", 32'(st), 3);
        run = 1'b0; fault = 1'b1;
        step();
        chk("fault_hold_fault", 32'(st), 3);
        fault = 1'b0;
        step();
        chk("fault_exit_state", 32'(st), 0);
        chk("fault_exit_latched", 32'(flt), 0);
        chk("fault_exit_carrier_rst", 32'(crst), 1);

        // Fault wins over IDLE->ARM
        run = 1'b1; fault = 1'b1;
        step();
        chk("fault_wins_state", 32'(st), 3);
        fault = 1'b0;
        step();
        chk("fault_needs_run_low", 32'(st), 3);
        run = 1'b0;
        step();
        chk("fault_to_idle", 32'(st), 0);

        // Stop request at tick 10 finishes the period
        manual = 1'b0; run = 1'b1;
        step();
        chk("restart_arm", 32'(st), 1);
        wait_ps(cyc, found);
        chk("restart_run_found", 32'(found), 1);
        chk("restart_run_state", 32'(st), 2);
        cyc = 0; found = 1'b0;
        while (!found && cyc < 400) begin
            step();
            cyc++;
            if (en && bt == 10) found = 1'b1;
        end
        chk("tick10_found", 32'(found), 1);
        run = 1'b0;
        cyc = 0; nhi = 0; nlo = 0;
        while (st == 2'd2 && cyc < 600) begin
            step();
            cyc++;
            if (hi) nhi++;
            if (lo) nlo++;
        end
        chk("stop_clocks", 32'(cyc), 504);
        chk("stop_state", 32'(st), 0);
        chk("stop_carrier_rst", 32'(crst), 1);
        chk("stop_gates", 32'({hi, lo}), 0);
        chk("stop_kept_modulating", 32'(nhi > 0 && nlo > 0), 1);

        // Reset mid-RUN drops gates immediately
        run = 1'b1;
        step();
        wait_ps(cyc, found);
        chk("rst_run_found", 32'(found), 1);
        cyc = 0; found = 1'b0;
        while (!found && cyc < 100) begin
            step();
            cyc++;
            if (hi) found = 1'b1;
        end
        chk("rst_run_hi_found", 32'(found), 1);
        rst_n = 1'b0;
        step();
        chk("midrun_rst_gates", 32'({hi, lo}), 0);
        chk("midrun_rst_state", 32'(st), 0);
        chk("midrun_rst_carrier_rst", 32'(crst), 1);
        chk("midrun_rst_carrier_en", 32'(en), 0);
        chk("midrun_rst_period_start", 32'(ps), 0);
        rst_n = 1'b1; run = 1'b0;
        step();
        chk("post_rst_idle", 32'(st), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_sequencer.md
PWM_SEQUENCER -- requirements
Module: pwm_sequencer

Interface
REQ-001 Parameter NB_DATA, 16, width of carrier and reference words, signed S(16,15).
REQ-002 Parameter DIV_RATIO, 24, clocks per carrier tick (5.4 MHz / 225 kHz).
REQ-003 Parameter PERIOD_TICKS, 31, carrier ticks per carrier period (sample counter 0..30).
REQ-004 Parameter DEAD_CYCLES, 8, dead-time in clocks; range 1..15.
REQ-005 i_clock  in  1  system clock, 5.4 MHz.
REQ-006 i_reset_n  in  1  reset, synchronous, active-low.
REQ-007 i_run  in  1  level request to modulate.
REQ-008 i_fault  in  1  level hardware fault (overcurrent/overvoltage).
REQ-009 i_carrier  in  NB_DATA  carrier sample from the carrier generator.
REQ-010 i_ref  in  NB_DATA  modulating reference, signed.
REQ-011 i_ref_valid  in  1  one-cycle qualifier for i_ref.
REQ-012 o_carrier_en  out  1  carrier tick strobe, one clock high.
REQ-013 o_carrier_rst  out  1  active-high reset to the carrier generator.
REQ-014 o_gate_hi / o_gate_lo  out  1 each  complementary switch gates.
REQ-015 o_period_start  out  1  one-clock pulse at carrier tick 0 of each period.
REQ-016 o_state  out  2  FSM state encoding; o_fault_latched  out  1  high in FAULT.

Function
REQ-017 The FSM SHALL have states IDLE=0, ARM=1, RUN=2, FAULT=3.
REQ-018 IDLE: o_carrier_rst=1, o_carrier_en=0, both gates 0; i_run=1 and i_fault=0 -> ARM.
REQ-019 ARM: o_carrier_rst=0, divider and tick counters cleared on entry, gates 0; after PERIOD_TICKS ticks -> RUN at the next tick 0.
REQ-020 Divider SHALL count 0..DIV_RATIO-1 in ARM/RUN, asserting o_carrier_en when the count equals DIV_RATIO-1; first strobe DIV_RATIO clocks after ARM entry.
REQ-021 Tick counter SHALL count strobes 0..PERIOD_TICKS-1 and wrap to 0; o_period_start pulses in the clock the counter wraps to 0.
REQ-022 Shadow register SHALL load i_ref on every i_ref_valid; active reference SHALL load from shadow only on o_period_start (glitch-free update); both reset to 0.
REQ-023 Raw PWM SHALL be (active_ref > i_carrier) as signed compare, registered, 1-clock latency.
REQ-024 On every raw PWM change both gates SHALL be 0 for exactly DEAD_CYCLES clocks, then the gate matching raw PWM asserts (1 -> o_gate_hi, 0 -> o_gate_lo).
REQ-025 A raw change during dead-time SHALL restart the dead counter with the new value.
REQ-026 o_gate_hi and o_gate_lo SHALL never be 1 in the same clock, in any state.
REQ-027 RUN with i_run=0: modulation continues to the end of the current period, then -> IDLE with gates 0 at the next tick 0.
REQ-028 i_fault=1 in any state SHALL force FAULT next clock; gates 0 and o_carrier_rst=1 from that clock on.
REQ-029 FAULT -> IDLE only when i_fault=0 and i_run=0 in the same clock.
REQ-030 Simultaneous i_fault and any other transition: fault wins.
REQ-031 Gates SHALL be 0 in IDLE, ARM and FAULT regardless of compare result.

Reset
REQ-032 i_reset_n=0 sampled on a rising edge SHALL put FSM in IDLE, clear all counters and registers, drive o_carrier_rst=1, all other outputs 0.
REQ-033 Reset asserted mid-RUN SHALL drop both gates in the clock following the sampled edge, no dead-time sequence.

Structure
REQ-034 State encodings and DIV_RATIO/PERIOD_TICKS defaults SHALL live in a shared package also used by the carrier generator.
REQ-035 Dead-time insertion SHALL be a sub-module, dead_time_gen (raw in, gate pair out, enable, reset).

Verification
REQ-036 Reset then i_run=1: o_carrier_en first at clock 24, every 24 clocks; RUN entered after 31 strobes; o_period_start every 744 clocks.
REQ-037 i_ref=0x4000 with triangular carrier: gate_hi duty approx 75% per period, each edge preceded by exactly 8 clocks both-low.
REQ-038 i_ref_valid with 0x2000 mid-period: active reference unchanged until next o_period_start.
REQ-039 i_fault pulsed 1 clock during gate_hi=1: gates 0 next clock, FAULT held until i_fault=0 and i_run=0, then IDLE.
REQ-040 Raw PWM toggled twice within 5 clocks: both gates 0 for 8 clocks after the last toggle; assertion gate_hi&gate_lo never fires.
REQ-041 i_run dropped at tick 10: gates keep modulating until tick 0, then IDLE, o_carrier_rst=1.
